// File: rtl/d_sram_to_sramlike_if.sv
// sram-like data bus between the CPU data-port adapter and the AXI bridge/cache.
// master: drives the request fields; slave: drives addr_ok/data_ok/rdata.
interface d_sram_to_sramlike_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req,
    output data_wr,
    output data_size,
    output data_addr,
    output data_wdata,
    input  data_addr_ok,
    input  data_data_ok,
    input  data_rdata
  );

  modport slave (
    input  data_req,
    input  data_wr,
    input  data_size,
    input  data_addr,
    input  data_wdata,
    output data_addr_ok,
    output data_data_ok,
    output data_rdata
  );
endinterface

// File: rtl/d_sram_to_sramlike.sv
// CPU data SRAM port -> sram-like bus; stalls the pipeline until done.
// Ports: clk/rst, data_sram_* CPU side, longest_stall/d_stall, bus (master).
module d_sram_to_sramlike (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic        longest_stall,
  output logic        d_stall,
  d_sram_to_sramlike_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ADDR,
    WAIT_DATA,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;

  logic byte_en;
  logic half_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (data_sram_en) begin
          if (bus.data_addr_ok && bus.data_data_ok) begin
            state_d = DONE;
            rdata_d = bus.data_rdata;
          end else if (bus.data_addr_ok) begin
            state_d = WAIT_DATA;
          end else begin
            state_d = WAIT_ADDR;
          end
        end
      end
      WAIT_ADDR: begin
        if (bus.data_addr_ok && bus.data_data_ok) begin
          state_d = DONE;
          rdata_d = bus.data_rdata;
        end else if (bus.data_addr_ok) begin
          state_d = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (bus.data_data_ok) begin
          state_d = DONE;
          rdata_d = bus.data_rdata;
        end
      end
      DONE: begin
        // hold the load data until the whole pipeline moves on
        if (!longest_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_en = data_sram_wen inside
    {4'b0001, 4'b0010, 4'b0100, 4'b1000};
  assign half_en = data_sram_wen inside
    {4'b0011, 4'b1100};

  always_comb begin
    bus.data_size = 2'd2;
    unique case (1'b1)
      byte_en: bus.data_size = 2'd0;
      half_en: bus.data_size = 2'd1;
      default: bus.data_size = 2'd2;
    endcase
  end

  assign bus.data_req =
    ((state_q == IDLE) && data_sram_en) ||
    (state_q == WAIT_ADDR);
  assign bus.data_wr    = |data_sram_wen;
  assign bus.data_addr  = data_sram_addr;
  assign bus.data_wdata = data_sram_wdata;

  assign d_stall         = data_sram_en && (state_q != DONE);
  assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_d_sram_to_sramlike.sv
// Randomized bench for d_sram_to_sramlike against a per-transaction
// timeline model (request/stall/rdata windows from the handshake delays).
module tb_d_sram_to_sramlike;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] sram_rdata;
  logic        longest_stall;
  logic        d_stall;

  d_sram_to_sramlike_if bus ();

  d_sram_to_sramlike dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (sram_rdata),
    .longest_stall   (longest_stall),
    .d_stall         (d_stall),
    .bus             (bus.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_rd;
  logic [3:0]  legal_wen [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100,
                                 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_size(input logic [3:0] w);
    int n;
    n = $countones(w);
    if (n == 1) return 2'd0;
    if (n == 2) return 2'd1;
    return 2'd2;
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bus_fields;
    check("wr", {31'd0, bus.data_wr}, {31'd0, |wen});
    check("size", {30'd0, bus.data_size}, {30'd0, exp_size(wen)});
    check("addr", bus.data_addr, addr);
    check("wdata", bus.data_wdata, wdata);
  endtask

  // One access: addr_ok at cycle a, data_ok at a+d, pipeline held h
  // extra cycles in DONE. Stall spans cycles 0..a+d, DONE a+d+1..a+d+1+h.
  task automatic run_txn(input logic [3:0] w, input logic [31:0] ad,
                         input logic [31:0] wd, input int a,
                         input int d, input int h,
                         input logic [31:0] rd);
    int t_done;
    t_done = a + d + 1;
    for (int c = 0; c <= t_done + h; c++) begin
      next_cycle();
      en    = 1'b1;
      wen   = w;
      addr  = ad;
      wdata = wd;
      bus.data_addr_ok = (c == a) ||
        ((c > a) && $urandom_range(0, 1) == 1);
      bus.data_data_ok = (c == a + d) ||
        (((c < a) || (c > a + d)) && $urandom_range(0, 1) == 1);
      bus.data_rdata = (c == a + d) ? rd : $urandom;
      longest_stall = (c < t_done + h);
      @(negedge clk);
      check("req", {31'd0, bus.data_req}, {31'd0, c <= a});
      check("stall", {31'd0, d_stall}, {31'd0, c < t_done});
      check_bus_fields();
      if (c >= t_done) check("rdata", sram_rdata, rd);
    end
    last_rd = rd;
  endtask

  task automatic idle_gap(input int n);
    for (int c = 0; c < n; c++) begin
      next_cycle();
      en    = 1'b0;
      wen   = legal_wen[$urandom_range(0, 7)];
      addr  = $urandom;
      wdata = $urandom;
      bus.data_addr_ok = ($urandom_range(0, 1) == 1);
      bus.data_data_ok = ($urandom_range(0, 1) == 1);
      bus.data_rdata   = $urandom;
      longest_stall    = 1'b0;
      @(negedge clk);
      check("idle_req", {31'd0, bus.data_req}, 32'd0);
      check("idle_stall", {31'd0, d_stall}, 32'd0);
      check("idle_rdata", sram_rdata, last_rd);
      check_bus_fields();
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    wen   = 4'b0000;
    addr  = '0;
    wdata = '0;
    longest_stall    = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'h1234_5678;
    last_rd = '0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_rdata", sram_rdata, 32'd0);
    check("rst_req", {31'd0, bus.data_req}, 32'd0);
    check("rst_stall", {31'd0, d_stall}, 32'd0);
    next_cycle();
    rst = 1'b0;

    idle_gap(3);
    run_txn(4'b0000, 32'h1FC0_0100, 32'h0, 0, 3, 0, 32'hDEAD_BEEF);
    run_txn(4'b0100, 32'h0000_0042, 32'h00AB_0000, 2, 1, 0,
            32'h5555_AAAA);
    run_txn(4'b0000, 32'h8000_0010, 32'h0, 0, 0, 0, 32'hCAFE_F00D);
    run_txn(4'b1111, 32'h8000_0020, 32'h1111_2222, 1, 0, 3,
            32'h0BAD_CAFE);
    idle_gap(4);

    // reset abandons an access stuck in WAIT_DATA
    next_cycle();
    en = 1'b1;
    wen = 4'b0000;
    addr = 32'h8000_0100;
    bus.data_addr_ok = 1'b1;
    bus.data_data_ok = 1'b0;
    longest_stall = 1'b1;
    @(negedge clk);
    check("abort_req0", {31'd0, bus.data_req}, 32'd1);
    next_cycle();
    bus.data_addr_ok = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_wait_req", {31'd0, bus.data_req}, 32'd0);
    check("abort_wait_stall", {31'd0, d_stall}, 32'd1);
    next_cycle();
    rst = 1'b0;
    en = 1'b0;
    longest_stall = 1'b0;
    @(negedge clk);
    check("abort_rdata", sram_rdata, 32'd0);
    check("abort_req", {31'd0, bus.data_req}, 32'd0);
    check("abort_stall", {31'd0, d_stall}, 32'd0);
    last_rd = '0;
    run_txn(4'b0011, 32'h0000_0004, 32'h0000_BEEF, 0, 1, 1,
            32'h7777_8888);

    for (int i = 0; i < 150; i++) begin
      run_txn(legal_wen[$urandom_range(0, 7)], $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 2) == 0) idle_gap($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
